// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - framed byte-stream loader that fills the processor RAM
// Accepts length, payload, checksum; emits one registered RAM write per payload byte.
module mem_loader #(
  parameter int address_length = 6,
  parameter int data_length    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [data_length-1:0]    in_data,
  output logic                      in_ready,
  output logic                      mem_wren,
  output logic [address_length-1:0] mem_address,
  output logic [data_length-1:0]    mem_write_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int CAP = 2 ** address_length;

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [address_length:0]   r_count;
  logic [address_length:0]   r_len;
  logic [data_length-1:0]    r_sum;
  logic                      r_wren;
  logic [address_length-1:0] r_addr;
  logic [data_length-1:0]    r_wdata;
  logic                      r_done;
  logic                      r_error;

  logic                      w_accept;
  logic                      w_len_bad;
  logic                      w_last;
  logic [address_length:0]   w_count_inc;
  logic [data_length-1:0]    w_sum_next;

  assign w_accept    = in_valid & in_ready;
  assign w_len_bad   = (in_data == '0) || (int'(in_data) > CAP);
  assign w_count_inc = r_count + (address_length + 1)'(1);
  assign w_last      = (w_count_inc == r_len);
  assign w_sum_next  = r_sum + in_data;

  // in_ready and busy depend on state only, so reset clears them immediately
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) w_next = LEN;
      end
      LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_next = w_len_bad ? ERR : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept && w_last) w_next = CSUM;
      end
      CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_accept) w_next = (in_data == r_sum) ? DONE : ERR;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_len   <= '0;
      r_sum   <= '0;
      r_wren  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wren  <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_count <= '0;
            r_sum   <= '0;
          end
        end
        LEN: begin
          if (w_accept) begin
            if (w_len_bad) r_error <= 1'b1;
            else           r_len   <= (address_length + 1)'(in_data);
          end
        end
        DATA: begin
          if (w_accept) begin
            r_wren  <= 1'b1;
            r_addr  <= r_count[address_length-1:0];
            r_wdata <= in_data;
            r_sum   <= w_sum_next;
            r_count <= w_count_inc;
          end
        end
        CSUM: begin
          if (w_accept) begin
            if (in_data == r_sum) r_done  <= 1'b1;
            else                  r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_wren       = r_wren;
  assign mem_address    = r_addr;
  assign mem_write_data = r_wdata;
  assign done           = r_done;
  assign error          = r_error;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed and randomized frames against a frame-level loader model
// Writes seen on the RAM port are collected and compared with the model's expected list.
module tb_mem_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_wren;
  logic [5:0] mem_address;
  logic [7:0] mem_write_data;
  logic       busy;
  logic       done;
  logic       error;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0] pl [64];
  int wq_addr [$];
  int wq_data [$];
  int wq_cyc  [$];

  mem_loader #(.address_length(6), .data_length(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wren(mem_wren), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && mem_wren) begin
      wq_addr.push_back(int'(mem_address));
      wq_data.push_back(int'(mem_write_data));
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  // Present one byte, optionally after random idle cycles; returns at accept edge + 1.
  task automatic send(input logic [7:0] b, input bit gaps);
    int budget;
    while (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    budget   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      budget++;
      if (budget > 200) begin
        check("handshake_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(in_ready), 32'd1);
    clear_writes();
  endtask

  // Frame model: illegal length -> error with no writes; otherwise writes (k, pl[k]) in
  // order and done exactly when the checksum matches the byte sum mod 256.
  task automatic run_frame(input int len, input logic [7:0] csum, input bit gaps,
                           input bit noisy_start, input bit contiguous);
    bit exp_bad;
    int sum;
    bit exp_done;
    int nw;
    do_start();
    exp_bad = (len == 0) || (len > 64);
    send(8'(len), gaps);
    sum = 0;
    if (!exp_bad) begin
      start = noisy_start;
      for (int k = 0; k < len; k++) begin
        send(pl[k], gaps);
        sum += int'(pl[k]);
      end
      start = 1'b0;
      send(csum, gaps);
    end
    exp_done = !exp_bad && (int'(csum) == (sum % 256));
    check("end_done", 32'(done), 32'(exp_done));
    check("end_error", 32'(error), 32'(!exp_done));
    check("end_busy", 32'(busy), 32'd0);
    check("end_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    nw = exp_bad ? 0 : len;
    check("write_count", 32'(wq_addr.size()), 32'(nw));
    for (int k = 0; k < nw && k < wq_addr.size(); k++) begin
      check("write_addr", 32'(wq_addr[k]), 32'(k));
      check("write_data", 32'(wq_data[k]), 32'(pl[k]));
      if (contiguous && k > 0) check("write_consecutive", 32'(wq_cyc[k] - wq_cyc[k-1]), 32'd1);
    end
  endtask

  initial begin
    int n;
    int s;
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h03;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_wdata", 32'(mem_write_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_wren", 32'(mem_wren), 32'd0);
      check("rst_busy_hold", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(busy), 32'd0);

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    run_frame(3, 8'h66, 1'b0, 1'b1, 1'b1);
    run_frame(3, 8'h67, 1'b0, 1'b0, 1'b1);
    run_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
    run_frame(8'h41, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 64; k++) pl[k] = 8'(k);
    run_frame(64, 8'hE0, 1'b1, 1'b0, 1'b0);

    do_start();
    send(8'h03, 1'b0);
    send(8'hA5, 1'b0);
    send(8'h5A, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wren", 32'(mem_wren), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    run_frame(4, 8'h0A, 1'b0, 1'b0, 1'b1);

    for (int f = 0; f < 12; f++) begin
      n = (f % 4 == 3) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 64));
      s = 0;
      for (int k = 0; k < 64; k++) begin
        pl[k] = 8'($urandom);
        if (k < n) s += int'(pl[k]);
      end
      if ($urandom_range(0, 1) == 1) s += int'($urandom_range(1, 255));
      run_frame(n, 8'(s), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program loader that fills the processor's 64x8 RAM from a byte stream before execution. It sits directly upstream of the RAM write port: it accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake and turns it into sequential single-cycle RAM write pulses. It holds the processor core halted while loading and reports completion or a framing/checksum error.

## Interface
- `address_length`, default 6: RAM address width. Capacity is 2**address_length bytes.
- `data_length`, default 8: RAM data width, stream byte width and checksum width.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load. Ignored while `busy`.
- `in_valid`  in  1  stream byte present on `in_data`.
- `in_data`  in  data_length  stream byte.
- `in_ready`  out  1  loader can accept a byte. A byte transfers on a clock edge where `in_valid` and `in_ready` are both 1.
- `mem_wren`  out  1  RAM write enable. Registered, one-cycle pulse per payload byte.
- `mem_address`  out  address_length  RAM write address. Registered.
- `mem_write_data`  out  data_length  RAM write data. Registered.
- `busy`  out  1  load in progress; drives the core halt.
- `done`  out  1  last load completed with a good checksum. Sticky.
- `error`  out  1  last load failed on length or checksum. Sticky.

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- Reset:
  - state = IDLE.
  - All outputs are 0: `in_ready`, `mem_wren`, `mem_address`, `mem_write_data`, `busy`, `done`, `error`.
  - Internal count, length and sum registers are 0.
- Transitions:
  - IDLE, DONE or ERR with `start`=1 -> LEN. This clears `done`, `error`, count and sum.
  - LEN: `in_ready`=1. The accepted byte is N.
    - N = 0 or N > 2**address_length -> ERR.
    - Otherwise latch N and go to DATA.
  - DATA: `in_ready`=1. Each accepted byte b (index k, counting from 0):
    - Next cycle: `mem_wren`=1, `mem_address`=k, `mem_write_data`=b.
    - sum <= (sum + b) mod 2**data_length.
    - After byte index N-1 -> CSUM.
  - CSUM: `in_ready`=1. The accepted byte c is compared with the new sum.
    - c == sum -> DONE, `done`=1.
    - c != sum -> ERR, `error`=1.
  - DONE and ERR: `in_ready`=0. These states hold until the next `start`.
- `busy` = 1 in LEN, DATA and CSUM; 0 otherwise.
- `in_ready` is a function of state only, never of `in_valid`.
- Count is address_length+1 bits wide so that N = 2**address_length is legal. The address is the low address_length bits of the count. The last address written is 2**address_length - 1; the count never wraps past it.
- `mem_address` and `mem_write_data` hold their last values when `mem_wren`=0.
- On an error, RAM contents are whatever was already written. No rollback.

## Timing
- `start` at edge t -> `busy`=1 and `in_ready`=1 from t+1.
- Payload handshake at edge t -> `mem_wren` pulse during cycle t+1. Latency is 1; at most one write per cycle.
- Back-to-back payload bytes give back-to-back write pulses, i.e. 1 byte/cycle throughput.
- Gaps in `in_valid` produce gaps in `mem_wren` and change no state.
- The write of the final payload byte and the checksum handshake may occur in the same cycle.
- CSUM handshake at edge t:
  - `done` or `error` = 1 from t+1.
  - `busy`=0 from t+1.
  - No `mem_wren` in cycle t+1 unless it is the final payload write.
- Length error in LEN at edge t -> `error`=1 and `busy`=0 from t+1.
- `start` while `busy` is ignored; the load continues.
- `rst` asserted mid-load: outputs go to 0 immediately, without waiting for `clk`. The state returns to IDLE and the partial RAM contents are retained.

## Test plan
- Reset check: assert `rst` with `in_valid`=1 and `start`=1 -> all outputs 0 and state IDLE while asserted, and no `mem_wren` pulse.
- Good short load: `start`, then stream 0x03, 0x11, 0x22, 0x33, 0x66 with no gaps -> writes (0,0x11), (1,0x22), (2,0x33) on consecutive cycles, then `done`=1, `error`=0, `busy`=0.
- Bad checksum: same frame with a final byte of 0x67 -> three writes occur, then `error`=1 and `done`=0.
- Length errors: N = 0x00 -> `error`=1 one cycle after the handshake with no writes; N = 0x41 -> same result.
- Full load with backpressure: N = 0x40, payload 0x00..0x3F, `in_valid` toggled at random, checksum 0xE0 (sum 2016 mod 256) -> 64 writes, with the last at address 63 and data 0x3F, then `done`=1.
- Mid-load reset and restart: pulse `rst` after 2 of 3 payload bytes, then run a complete good load -> `busy` drops immediately on reset, and the new load writes from address 0 and ends with `done`=1.
